// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, the data-memory
// responder FSM state type and a funct3 legality helper.
package riscv_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the response wait counter (WAIT_CYCLES is limited to 0..15)
  localparam int WAIT_CNT_W = 4;

  // Data-memory responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic legal;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for RV32I loads/stores: store byte enables and
// replicated write data, load extraction with sign/zero extension, and
// natural-alignment checking of the byte offset.
module dmem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rshift_s;
  logic [7:0]  rbyte_s;
  logic [15:0] rhalf_s;

  // Bring the addressed byte/half down to bit 0 of the read word
  always_comb begin
    rshift_s = rword >> {addr_lo, 3'b000};
    rbyte_s  = rshift_s[7:0];
    rhalf_s  = rshift_s[15:0];
  end

  // Decode funct3 into lanes, write-data replication and load extension
  always_comb begin
    be         = 4'b0000;
    wdata_sh   = 32'd0;
    rdata_ext  = 32'd0;
    misaligned = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{rbyte_s[7]}}, rbyte_s};
      end
      F3_BU: begin
        rdata_ext = {24'd0, rbyte_s};
      end
      F3_H: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf_s[15]}}, rhalf_s};
      end
      F3_HU: begin
        misaligned = addr_lo[0];
        rdata_ext  = {16'd0, rhalf_s};
      end
      F3_W: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata_sh   = wdata;
        rdata_ext  = rword;
      end
      default: begin
        be         = 4'b0000;
        wdata_sh   = 32'd0;
        rdata_ext  = 32'd0;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: memory side of the core load/store handshake.
// Accepts one request at a time, checks alignment, range and funct3,
// performs byte-lane stores and extended loads on the acceptance edge,
// and presents the response after WAIT_CYCLES extra cycles.
module dmem_resp
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // WAIT holds for WAIT_LOAD+1 cycles, so the response lands WAIT_CYCLES
  // cycles later than the zero-wait case.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : {WAIT_CNT_W{1'b0}};

  logic [31:0] mem_r [0:DEPTH-1];

  dmem_state_t           state_r;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic                  req_ready_r;
  logic                  resp_valid_r;
  logic [31:0]           resp_rdata_r;
  logic                  resp_err_r;

  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [31:0]           rword_s;
  logic                  accept_s;
  logic                  range_err_s;
  logic                  f3_err_s;
  logic                  misaligned_s;
  logic                  req_err_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_sh_s;
  logic [31:0]           rdata_ext_s;

  dmem_align u_align (
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .rword      (rword_s),
    .be         (be_s),
    .wdata_sh   (wdata_sh_s),
    .rdata_ext  (rdata_ext_s),
    .misaligned (misaligned_s)
  );

  // Request decode: word index, asynchronous RAM read and error checks
  always_comb begin
    word_idx_s  = req_addr[ADDR_WIDTH+1:2];
    rword_s     = mem_r[word_idx_s];
    // Any address bit above the RAM window is an error; no wrap-around.
    range_err_s = ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    f3_err_s    = ~f3_legal(req_we, req_funct3);
    req_err_s   = misaligned_s | range_err_s | f3_err_s;
    accept_s    = (state_r == IDLE) & req_valid;
  end

  // Byte-lane RAM write on the acceptance edge of an error-free store
  always_ff @(posedge clk) begin
    if (!rst && accept_s && req_we && !req_err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM with wait counter and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      wait_cnt_r   <= {WAIT_CNT_W{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready_r  <= 1'b0;
            resp_err_r   <= req_err_s;
            // Stores and errors always answer with zero data.
            resp_rdata_r <= (req_we || req_err_s) ? 32'd0 : rdata_ext_s;
            if (WAIT_CYCLES > 0) begin
              state_r    <= WAIT;
              wait_cnt_r <= WAIT_LOAD;
            end else begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt_r == {WAIT_CNT_W{1'b0}}) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          // Data/err stay frozen until the requester takes the response.
          if (resp_ready) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          wait_cnt_r   <= {WAIT_CNT_W{1'b0}};
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed vector table and randomized
// traffic on a zero-wait instance, multi-cycle corner cases on a
// three-wait instance.
module tb_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, resp_err0;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0;
  logic [2:0]  req_funct30;

  logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [2:0]  req_funct31;

  dmem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  dmem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_funct3(req_funct31),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  int checks = 0;
  int errors = 0;

  // Reference byte memory, addressed by byte address
  logic [7:0] ref_mem [int];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? req_ready0 : req_ready1;
  endfunction
  function automatic logic get_vld(input int d);
    return (d == 0) ? resp_valid0 : resp_valid1;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? resp_rdata0 : resp_rdata1;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? resp_err0 : resp_err1;
  endfunction

  task automatic drive_req(input int d, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
    if (d == 0) begin
      req_valid0 = v; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_funct30 = f3;
    end else begin
      req_valid1 = v; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata; req_funct31 = f3;
    end
  endtask

  task automatic set_rready(input int d, input logic v);
    if (d == 0) resp_ready0 = v;
    else        resp_ready1 = v;
  endtask

  // Behavioural model straight from the RV32I access rules
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] r, output logic e);
    int     n;
    bit     legal;
    bit     sgn;
    longint v;
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sgn = (f3 == 3'd0 || f3 == 3'd1);
    n   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    e   = !legal || ((addr % n) != 0) || (addr >= 32'd4096);
    r   = 32'd0;
    if (!e && we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else if (!e) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      r = v[31:0];
    end
  endtask

  // One full request/response; called and returning on a negedge
  task automatic xact(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3, input int stall,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    logic [31:0] fr;
    logic        fe;
    n = 0;
    while (!get_rdy(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout actual=0 expected=1");
    end
    drive_req(d, 1'b1, we, addr, wdata, f3);
    @(posedge clk);
    @(negedge clk);
    drive_req(d, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    lat = 1;
    while (!get_vld(d) && lat < 60) begin
      chk("req_ready_in_wait", {31'd0, get_rdy(d)}, 32'd0);
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) begin
      checks++; errors++;
      $display("FAIL resp_valid_timeout actual=0 expected=1");
    end
    rdata = get_rdata(d);
    err   = get_err(d);
    fr    = rdata;
    fe    = err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, get_vld(d)}, 32'd1);
      chk("stall_rdata", get_rdata(d), fr);
      chk("stall_err", {31'd0, get_err(d)}, {31'd0, fe});
      chk("stall_req_ready", {31'd0, get_rdy(d)}, 32'd0);
    end
    set_rready(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rready(d, 1'b0);
    chk("valid_after_hs", {31'd0, get_vld(d)}, 32'd0);
    chk("ready_after_hs", {31'd0, get_rdy(d)}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, er_rd;
    logic        er, er_e;
    int          lat;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          r;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0011, 32'h0000_0080, 3'b000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 3'b000, 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 3'b100, 32'h0000_0080, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_80EF, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 3'b001, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_0012, 32'h1234_5678, 3'b010, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_80EF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b011, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 3'b100, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_80EF, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0012, 32'hA5A5_8001, 3'b001, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 3'b001, 32'hFFFF_8001, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 3'b101, 32'h0000_8001, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h8001_80EF, 1'b0};
    vecs[17] = '{1'b1, 32'h0000_0FFC, 32'h1122_3344, 3'b010, 32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 32'h0000_0FFF, 32'h0000_0000, 3'b100, 32'h0000_0011, 1'b0};
    vecs[19] = '{1'b0, 32'h0000_0FFE, 32'h0000_0000, 3'b000, 32'h0000_0022, 1'b0};
    vecs[20] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 3'b010, 32'h1122_3344, 1'b0};
    vecs[21] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1};
    vecs[22] = '{1'b1, 32'h0000_0FFE, 32'h0000_BEEF, 3'b001, 32'h0000_0000, 1'b0};
    vecs[23] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 3'b010, 32'hBEEF_3344, 1'b0};

    rst = 1'b1;
    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready0", {31'd0, req_ready0}, 32'd1);
    chk("rst_resp_valid0", {31'd0, resp_valid0}, 32'd0);
    chk("rst_resp_rdata0", resp_rdata0, 32'd0);
    chk("rst_resp_err0", {31'd0, resp_err0}, 32'd0);
    chk("rst_req_ready1", {31'd0, req_ready1}, 32'd1);
    chk("rst_resp_valid1", {31'd0, resp_valid1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, zero-wait instance
    for (int i = 0; i < 24; i++) begin
      xact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, 0, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, 32'd1);
    end

    // Randomized traffic against the byte model; fill the window first
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model(1'b1, 32'(w * 4), wd, 3'b010, er_rd, er_e);
      xact(0, 1'b1, 32'(w * 4), wd, 3'b010, 0, rd, er, lat);
      chk("fill_err", {31'd0, er}, 32'd0);
    end
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      wd = $urandom;
      r  = int'($urandom % 16);
      if (r == 0)      addr = 32'h0000_1000 + 32'($urandom % 4096);
      else if (r == 1) addr = {1'b1, 31'($urandom)};
      else             addr = 32'($urandom % 256);
      model(we, addr, wd, f3, er_rd, er_e);
      xact(0, we, addr, wd, f3, 0, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", k), rd, er_rd);
      chk($sformatf("rnd%0d_err", k), {31'd0, er}, {31'd0, er_e});
      chk($sformatf("rnd%0d_lat", k), lat, 32'd1);
    end

    // Three-wait instance: latency, stalled response, error path
    xact(1, 1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, 0, rd, er, lat);
    chk("w3_sw_rdata", rd, 32'd0);
    chk("w3_sw_err", {31'd0, er}, 32'd0);
    chk("w3_sw_lat", lat, 32'd4);
    xact(1, 1'b0, 32'h20, 32'd0, 3'b010, 5, rd, er, lat);
    chk("w3_lw_rdata", rd, 32'hCAFE_F00D);
    chk("w3_lw_err", {31'd0, er}, 32'd0);
    chk("w3_lw_lat", lat, 32'd4);
    xact(1, 1'b0, 32'h21, 32'd0, 3'b001, 2, rd, er, lat);
    chk("w3_mis_rdata", rd, 32'd0);
    chk("w3_mis_err", {31'd0, er}, 32'd1);
    chk("w3_mis_lat", lat, 32'd4);

    // Reset pulse while a store waits: response dropped, store kept
    drive_req(1, 1'b1, 1'b1, 32'h24, 32'h5A5A_1234, 3'b010);
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_req_ready", {31'd0, req_ready1}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      chk("rst_wait_no_valid", {31'd0, resp_valid1}, 32'd0);
      @(negedge clk);
    end
    xact(1, 1'b0, 32'h24, 32'd0, 3'b010, 0, rd, er, lat);
    chk("rst_kept_store", rd, 32'h5A5A_1234);
    chk("rst_kept_err", {31'd0, er}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
